// File: rtl/cmprs_vsync_late_gen.sv
// cmprs_vsync_late_gen: delayed frame-start pulse fired a programmable number of lines after sof.
// Optional forced-fire timeout enabled by defining VSYNC_LATE_TIMEOUT_EN.
module cmprs_vsync_late_gen #(
    parameter int FRAME_HEIGHT_BITS  = 16,
    parameter int LAST_FRAME_BITS    = 16,
    parameter int DFLT_LINE_DELAY    = 16,
    parameter int VLATE_TIMEOUT_BITS = 20
) (
    input  logic                          xclk,
    input  logic                          xrst_n,
    input  logic                          en,
    input  logic                          sof,
    input  logic                          eol,
    input  logic                          cfg_we,
    input  logic [FRAME_HEIGHT_BITS-1:0]  cfg_delay,
    input  logic [VLATE_TIMEOUT_BITS-1:0] cfg_timeout,
    output logic                          vsync_late,
    output logic                          waiting,
    output logic [FRAME_HEIGHT_BITS-1:0]  line_cnt,
    output logic [LAST_FRAME_BITS-1:0]    frame_num,
    output logic                          restarted,
    output logic                          timed_out
);
    typedef enum logic [1:0] {IDLE, WAIT, FIRE, WAIT_SOF} state_t;
    state_t state;
    logic [FRAME_HEIGHT_BITS-1:0] shadow, delay;
    assign waiting = state == WAIT;
`ifdef VSYNC_LATE_TIMEOUT_EN
    logic [VLATE_TIMEOUT_BITS-1:0] tmo_cnt;
    logic tmo_on;
`else
    logic unused_timeout;
    assign unused_timeout = ^cfg_timeout;
    assign timed_out = 1'b0;
`endif
    always_ff @(posedge xclk or negedge xrst_n) begin
        if (!xrst_n) begin
            state      <= IDLE;
            vsync_late <= 1'b0;
            line_cnt   <= '0;
            frame_num  <= '0;
            restarted  <= 1'b0;
            shadow     <= FRAME_HEIGHT_BITS'(DFLT_LINE_DELAY);
            delay      <= FRAME_HEIGHT_BITS'(DFLT_LINE_DELAY);
`ifdef VSYNC_LATE_TIMEOUT_EN
            timed_out  <= 1'b0;
            tmo_cnt    <= '0;
            tmo_on     <= 1'b0;
`endif
        end else begin
            vsync_late <= 1'b0;
            // clears come first so a same-cycle setting event wins
            if (cfg_we) begin
                shadow    <= cfg_delay;
                restarted <= 1'b0;
            end
`ifdef VSYNC_LATE_TIMEOUT_EN
            if (cfg_we) timed_out <= 1'b0;
`endif
            if (!en) begin
                state <= IDLE;
            end else begin
                if (state == FIRE) begin
                    vsync_late <= 1'b1;
                    frame_num  <= frame_num + 1'b1;
                    state      <= WAIT_SOF;
                end
                if (sof) begin
                    if (state == WAIT) restarted <= 1'b1;
                    state    <= WAIT;
                    line_cnt <= '0;
                    delay    <= shadow;
`ifdef VSYNC_LATE_TIMEOUT_EN
                    tmo_cnt  <= cfg_timeout;
                    tmo_on   <= |cfg_timeout;
`endif
                end else if (state == WAIT) begin
                    if (eol && !(&line_cnt)) line_cnt <= line_cnt + 1'b1;
                    if (line_cnt == delay) state <= FIRE;
`ifdef VSYNC_LATE_TIMEOUT_EN
                    else if (tmo_on && tmo_cnt == '0) begin
                        state     <= FIRE;
                        timed_out <= 1'b1;
                    end
                    if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_cmprs_vsync_late_gen.sv
// tb_cmprs_vsync_late_gen: table-driven latency checks, corner sequences and a randomized
// run, all shadowed cycle-by-cycle by a due-time reference model.
module tb_cmprs_vsync_late_gen;
    logic xclk = 0, xrst_n = 0, en = 0, sof = 0, eol = 0, cfg_we = 0;
    logic [15:0] cfg_delay = 0;
    logic [19:0] cfg_timeout = 0;
    logic vsync_late, waiting, restarted, timed_out;
    logic [15:0] line_cnt, frame_num;

    cmprs_vsync_late_gen dut (
        .xclk(xclk), .xrst_n(xrst_n), .en(en), .sof(sof), .eol(eol), .cfg_we(cfg_we),
        .cfg_delay(cfg_delay), .cfg_timeout(cfg_timeout), .vsync_late(vsync_late),
        .waiting(waiting), .line_cnt(line_cnt), .frame_num(frame_num),
        .restarted(restarted), .timed_out(timed_out)
    );

    always #5 xclk = ~xclk;

    int checks = 0, failures = 0, cyc = 0, pulses = 0, last_evt = 0;
    // model: a frame is "counting" until its line target is seen, then the pulse is due at a known cycle
    bit m_cnting = 0, m_vs = 0, m_restart = 0;
    int m_cnt = 0, m_dly = 16, m_shadow = 16, m_due = -1, m_frame = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnting = 0; m_vs = 0; m_restart = 0; m_cnt = 0;
        m_dly = 16; m_shadow = 16; m_due = -1; m_frame = 0;
    endtask

    task automatic model_step();
        bit was, hit;
        cyc++;
        if (!xrst_n) begin
            model_reset();
            return;
        end
        m_vs = 0;
        if (cfg_we) m_restart = 0;
        if (!en) begin
            m_cnting = 0;
            m_due = -1;
        end else begin
            was = m_cnting;
            hit = was && (m_cnt == m_dly);
            if (m_due == cyc) begin
                m_vs = 1;
                m_frame = (m_frame + 1) & 16'hffff;
                m_due = -1;
            end
            if (sof) begin
                if (was) m_restart = 1;
                m_cnting = 1;
                m_cnt = 0;
                m_dly = m_shadow;
            end else if (was) begin
                if (eol && m_cnt < 65535) m_cnt++;
                if (hit) begin
                    m_cnting = 0;
                    m_due = cyc + 1;
                end
            end
        end
        if (cfg_we) m_shadow = cfg_delay;
    endtask

    task automatic compare();
        chk("vsync_late", int'(vsync_late), int'(m_vs));
        chk("waiting", int'(waiting), int'(m_cnting));
        chk("line_cnt", int'(line_cnt), m_cnt);
        chk("frame_num", int'(frame_num), m_frame);
        chk("restarted", int'(restarted), int'(m_restart));
        chk("timed_out", int'(timed_out), 0);
    endtask

    task automatic tick();
        @(posedge xclk);
        model_step();
        #1;
        compare();
        if (vsync_late) pulses++;
    endtask

    task automatic set_delay(int d);
        cfg_delay = 16'(d); cfg_we = 1; tick(); cfg_we = 0; tick();
    endtask

    task automatic pulse_sof();
        sof = 1; tick(); sof = 0; last_evt = cyc;
    endtask

    task automatic eols(int n, int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) tick();
            eol = 1; tick(); eol = 0; last_evt = cyc;
        end
    endtask

    task automatic await_pulse(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (vsync_late) begin
                lat = cyc - last_evt;
                break;
            end
        end
    endtask

    typedef struct { int dly; int neol; int gap; int exp_lat; } vec_t;
    vec_t vecs[4];

    initial begin
        int lat, exp_frame;
        vecs[0] = '{16, 16, 100, 2};
        vecs[1] = '{0, 0, 1, 2};
        vecs[2] = '{3, 3, 1, 2};
        vecs[3] = '{1, 1, 5, 2};

        tick(); tick();
        chk("reset_vsync", int'(vsync_late), 0);
        chk("reset_frame", int'(frame_num), 0);
        chk("reset_waiting", int'(waiting), 0);
        xrst_n = 1; en = 1;
        tick();

        exp_frame = 0;
        foreach (vecs[i]) begin
            set_delay(vecs[i].dly);
            pulses = 0;
            pulse_sof();
            eols(vecs[i].neol, vecs[i].gap);
            await_pulse(lat);
            exp_frame++;
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_pulses", i), pulses, 1);
            chk($sformatf("vec%0d_frame", i), int'(frame_num), exp_frame);
        end

        // delay 0: eol ignored, second sof gives a second pulse
        set_delay(0);
        pulses = 0;
        eol = 1; pulse_sof(); eol = 0;
        await_pulse(lat);
        chk("d0_first_latency", lat, 2);
        pulse_sof();
        await_pulse(lat);
        chk("d0_second_latency", lat, 2);
        chk("d0_pulses", pulses, 2);

        // restart mid-frame: only the second frame fires
        set_delay(10);
        pulses = 0;
        pulse_sof(); eols(5, 2);
        pulse_sof(); eols(10, 2);
        await_pulse(lat);
        chk("restart_latency", lat, 2);
        chk("restart_pulses", pulses, 1);
        chk("restart_flag", int'(restarted), 1);

        // delay change mid-frame applies only to the next frame
        set_delay(8);
        pulses = 0;
        pulse_sof(); eols(3, 2);
        set_delay(4);
        eols(5, 2);
        await_pulse(lat);
        chk("midcfg_first_latency", lat, 2);
        pulse_sof(); eols(4, 2);
        await_pulse(lat);
        chk("midcfg_second_latency", lat, 2);
        chk("midcfg_pulses", pulses, 2);

        // en drop after 3 of 8 lines
        set_delay(8);
        pulses = 0;
        pulse_sof(); eols(3, 2);
        en = 0; tick();
        eols(5, 2);
        chk("endrop_pulses", pulses, 0);
        chk("endrop_line_cnt", int'(line_cnt), 3);
        en = 1;
        pulse_sof(); eols(8, 2);
        await_pulse(lat);
        chk("endrop_resume_latency", lat, 2);

        // async reset mid-WAIT takes effect without a clock edge
        pulse_sof(); eols(2, 2);
        #2 xrst_n = 0;
        #1;
        model_reset();
        chk("async_rst_waiting", int'(waiting), 0);
        chk("async_rst_line_cnt", int'(line_cnt), 0);
        chk("async_rst_frame", int'(frame_num), 0);
        chk("async_rst_vsync", int'(vsync_late), 0);
        tick();
        xrst_n = 1;
        tick();

        for (int i = 0; i < 4000; i++) begin
            en = $urandom_range(0, 199) != 0;
            sof = $urandom_range(0, 29) == 0;
            eol = $urandom_range(0, 3) == 0;
            cfg_we = $urandom_range(0, 59) == 0;
            cfg_delay = 16'($urandom_range(0, 6));
            tick();
        end
        en = 1; sof = 0; eol = 0; cfg_we = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
